imem_port_arbiter: RTL and testbench

- Owns the single byte-wide, synchronous-read port of the instruction memory.
- Shares that port between the fetch stage, which needs a 32-bit big-endian instruction assembled from 4 consecutive bytes, and a program loader, which writes single bytes.
- Sequences the 4 byte reads itself and arbitrates fairly (round-robin) between fetch and load requests.
- Sits between the PC/fetch logic, the loader, and a plain 1024x8 memory array.

---
 rtl/imem_port_arbiter_if.sv | 33 +++
 rtl/imem_port_arbiter.sv | 127 ++++++++++++
 tb/tb_imem_port_arbiter.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/imem_port_arbiter_if.sv
// Bundle of fetch, loader and memory-port signals around the instruction memory arbiter.
// The arbiter uses the slave view; requesters and the memory array use the master view.
interface imem_port_arbiter_if #(
    parameter int unsigned ADDR_W = 10
) ();
    // Fetch side
    logic              fetch_req;
    logic [ADDR_W-1:0] fetch_pc;
    logic              fetch_gnt;
    logic              fetch_valid;
    logic [31:0]       instruct;
    // Loader side
    logic              load_req;
    logic [ADDR_W-1:0] load_addr;
    logic [7:0]        load_data;
    logic              load_gnt;
    // Status and memory port
    logic              busy;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_we;
    logic [7:0]        mem_wdata;
    logic [7:0]        mem_rdata;

    modport slave (
        input  fetch_req, fetch_pc, load_req, load_addr, load_data, mem_rdata,
        output fetch_gnt, fetch_valid, instruct, load_gnt, busy, mem_addr, mem_we, mem_wdata
    );

    modport master (
        output fetch_req, fetch_pc, load_req, load_addr, load_data, mem_rdata,
        input  fetch_gnt, fetch_valid, instruct, load_gnt, busy, mem_addr, mem_we, mem_wdata
    );
endinterface

// File: rtl/imem_port_arbiter.sv
// Shares the byte-wide synchronous-read instruction memory port between the fetch stage
// (4-byte big-endian reads) and the program loader (single-byte writes), round-robin.
module imem_port_arbiter #(
    parameter int unsigned ADDR_W = 10
) (
    input logic                clk,
    input logic                rst,
    imem_port_arbiter_if.slave bus
);

    typedef enum logic [1:0] {StIdle, StRd, StFlush, StWrite} state_e;

    state_e            state_q, state_d;
    logic [1:0]        k_q;
    logic [ADDR_W-1:0] pc_q;
    logic [ADDR_W-1:0] waddr_q;
    logic [7:0]        wdata_q;
    logic [2:0][7:0]   bytes_q;      // bytes_q[0] is the MSB (byte at pc)
    logic [31:0]       instruct_q;
    logic              valid_q;
    logic              last_fetch_q; // 1: fetch won the most recent grant
    logic              fetch_sel;
    logic              load_sel;

    // Accept decision: only in IDLE, never under reset; ties go to whoever did not win last
    always_comb begin
        fetch_sel = 1'b0;
        load_sel  = 1'b0;
        if (state_q == StIdle && !rst) begin
            if (bus.fetch_req && (!bus.load_req || !last_fetch_q)) begin
                fetch_sel = 1'b1;
            end else if (bus.load_req) begin
                load_sel = 1'b1;
            end
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (fetch_sel) begin
                    state_d = StRd;
                end else if (load_sel) begin
                    state_d = StWrite;
                end
            end
            StRd:    if (k_q == 2'd3) state_d = StFlush;
            StFlush: state_d = StIdle;
            StWrite: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Outputs: grants, memory port drive and registered fetch result
    always_comb begin
        bus.fetch_gnt   = fetch_sel;
        bus.load_gnt    = load_sel;
        bus.busy        = (state_q != StIdle);
        bus.fetch_valid = valid_q;
        bus.instruct    = instruct_q;
        bus.mem_we      = 1'b0;
        bus.mem_addr    = '0;
        bus.mem_wdata   = '0;
        unique case (state_q)
            // Address arithmetic wraps naturally at the top of memory
            StRd: bus.mem_addr = pc_q + ADDR_W'(k_q);
            // A write already in progress completes even if rst is high this cycle
            StWrite: begin
                bus.mem_we    = 1'b1;
                bus.mem_addr  = waddr_q;
                bus.mem_wdata = wdata_q;
            end
            default: ;
        endcase
    end

    // Request latching, byte capture and instruction assembly
    always_ff @(posedge clk) begin
        if (rst) begin
            k_q          <= 2'd0;
            pc_q         <= '0;
            waddr_q      <= '0;
            wdata_q      <= 8'h00;
            bytes_q      <= '0;
            instruct_q   <= 32'h0;
            valid_q      <= 1'b0;
            last_fetch_q <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (fetch_sel) begin
                        pc_q         <= bus.fetch_pc;
                        k_q          <= 2'd0;
                        last_fetch_q <= 1'b1;
                    end else if (load_sel) begin
                        waddr_q      <= bus.load_addr;
                        wdata_q      <= bus.load_data;
                        last_fetch_q <= 1'b0;
                    end
                end
                StRd: begin
                    // Read data lags the address by one cycle
                    if (k_q != 2'd0) bytes_q[k_q - 2'd1] <= bus.mem_rdata;
                    k_q <= k_q + 2'd1;
                end
                StFlush: begin
                    instruct_q <= {bytes_q[0], bytes_q[1], bytes_q[2], bus.mem_rdata};
                    valid_q    <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_imem_port_arbiter.sv
// Directed self-checking bench for imem_port_arbiter with a behavioural 1024x8 memory.
module tb_imem_port_arbiter;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_fail = 0;

    imem_port_arbiter_if #(.ADDR_W(10)) bus ();

    imem_port_arbiter #(.ADDR_W(10)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Memory model with a backdoor write port for preloading
    logic [7:0] mem [0:1023];
    logic       bd_we = 1'b0;
    logic [9:0] bd_addr = '0;
    logic [7:0] bd_data = '0;

    always @(posedge clk) begin
        if (bd_we) mem[bd_addr] <= bd_data;
        else if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
        bus.mem_rdata <= mem[bus.mem_addr];
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic preload(input logic [9:0] a, input logic [7:0] d);
        bd_we   = 1'b1;
        bd_addr = a;
        bd_data = d;
        step();
        bd_we = 1'b0;
    endtask

    // Full fetch transaction: grant at T, addresses T+1..T+4, FLUSH T+5, result at T+6
    task automatic do_fetch(input logic [9:0] pc, input logic [31:0] exp_word);
        bus.fetch_req = 1'b1;
        bus.fetch_pc  = pc;
        #1;
        check("fetch_gnt@T", 32'(bus.fetch_gnt), 32'd1);
        check("load_gnt@T", 32'(bus.load_gnt), 32'd0);
        step();
        bus.fetch_req = 1'b0;
        for (int k = 0; k < 4; k++) begin
            check("rd_addr", 32'(bus.mem_addr), 32'((pc + 10'(k)) & 10'h3FF));
            check("rd_busy", 32'(bus.busy), 32'd1);
            check("rd_valid", 32'(bus.fetch_valid), 32'd0);
            step();
        end
        check("flush_addr", 32'(bus.mem_addr), 32'd0);
        check("flush_valid", 32'(bus.fetch_valid), 32'd0);
        step();
        check("valid@T6", 32'(bus.fetch_valid), 32'd1);
        check("instruct@T6", bus.instruct, exp_word);
        check("busy@T6", 32'(bus.busy), 32'd0);
        step();
        check("valid@T7", 32'(bus.fetch_valid), 32'd0);
        check("instruct_hold", bus.instruct, exp_word);
    endtask

    // Single loader write: grant at T, write cycle T+1, idle again at T+2
    task automatic do_load(input logic [9:0] a, input logic [7:0] d);
        bus.load_req  = 1'b1;
        bus.load_addr = a;
        bus.load_data = d;
        #1;
        check("load_gnt@T", 32'(bus.load_gnt), 32'd1);
        check("we@T", 32'(bus.mem_we), 32'd0);
        step();
        bus.load_req = 1'b0;
        check("we@T1", 32'(bus.mem_we), 32'd1);
        check("waddr@T1", 32'(bus.mem_addr), 32'(a));
        check("wdata@T1", 32'(bus.mem_wdata), 32'(d));
        check("busy@T1", 32'(bus.busy), 32'd1);
        check("load_gnt@T1", 32'(bus.load_gnt), 32'd0);
        step();
        check("we@T2", 32'(bus.mem_we), 32'd0);
        check("busy@T2", 32'(bus.busy), 32'd0);
    endtask

    initial begin
        int         gcount;
        logic [3:0] order;
        logic       pend_w;
        logic [9:0] pend_addr;
        logic [7:0] pend_data;
        logic       last_was_load;

        bus.fetch_req = 1'b1;
        bus.fetch_pc  = '0;
        bus.load_req  = 1'b1;
        bus.load_addr = '0;
        bus.load_data = '0;
        #1;
        check("rst_fetch_gnt", 32'(bus.fetch_gnt), 32'd0);
        check("rst_load_gnt", 32'(bus.load_gnt), 32'd0);
        bus.fetch_req = 1'b0;
        bus.load_req  = 1'b0;
        step();
        preload(10'h010, 8'h12);
        preload(10'h011, 8'h34);
        preload(10'h012, 8'h56);
        preload(10'h013, 8'h78);
        preload(10'h014, 8'h9A);
        preload(10'h3FE, 8'hAA);
        preload(10'h3FF, 8'hBB);
        preload(10'h000, 8'hCC);
        preload(10'h001, 8'hDD);
        rst = 1'b0;
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_valid", 32'(bus.fetch_valid), 32'd0);
        check("rst_instruct", bus.instruct, 32'h0);
        check("rst_we", 32'(bus.mem_we), 32'd0);
        check("rst_addr", 32'(bus.mem_addr), 32'd0);

        // Aligned fetch, then a fetch wrapping past the top of memory
        do_fetch(10'h010, 32'h12345678);
        do_fetch(10'h3FE, 32'hAABBCCDD);

        // Single write, then back-to-back writes followed by a fetch of them
        do_load(10'h005, 8'h5A);
        do_load(10'h040, 8'hDE);
        do_load(10'h041, 8'hAD);
        do_load(10'h042, 8'hBE);
        do_load(10'h043, 8'hEF);
        do_fetch(10'h040, 32'hDEADBEEF);

        // Reset in the RD cycle with k=2 aborts the fetch
        bus.fetch_req = 1'b1;
        bus.fetch_pc  = 10'h010;
        #1;
        check("abort_gnt", 32'(bus.fetch_gnt), 32'd1);
        step();
        bus.fetch_req = 1'b0;
        step();
        step();
        check("abort_k2_addr", 32'(bus.mem_addr), 32'h012);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("abort_busy", 32'(bus.busy), 32'd0);
        check("abort_instruct", bus.instruct, 32'h0);
        check("abort_addr", 32'(bus.mem_addr), 32'd0);
        for (int i = 0; i < 8; i++) begin
            check("abort_no_valid", 32'(bus.fetch_valid), 32'd0);
            step();
        end
        do_fetch(10'h011, 32'h3456789A);

        // Both requesting after reset: fetch, load, fetch, load
        rst = 1'b1;
        step();
        rst = 1'b0;
        bus.fetch_req = 1'b1;
        bus.fetch_pc  = 10'h010;
        bus.load_req  = 1'b1;
        bus.load_addr = 10'h020;
        bus.load_data = 8'h11;
        gcount = 0;
        order  = 4'b0;
        pend_w = 1'b0;
        pend_addr = '0;
        pend_data = '0;
        for (int c = 0; c < 80 && !(gcount == 4 && !pend_w); c++) begin
            #1;
            last_was_load = 1'b0;
            if (pend_w) begin
                check("tie_we", 32'(bus.mem_we), 32'd1);
                check("tie_waddr", 32'(bus.mem_addr), 32'(pend_addr));
                check("tie_wdata", 32'(bus.mem_wdata), 32'(pend_data));
                pend_w = 1'b0;
            end
            if (bus.fetch_valid) check("tie_instruct", bus.instruct, 32'h12345678);
            check("tie_exclusive", 32'(bus.fetch_gnt & bus.load_gnt), 32'd0);
            if ((bus.fetch_gnt || bus.load_gnt) && gcount < 4) begin
                order[gcount] = bus.load_gnt;
                gcount++;
                if (bus.load_gnt) begin
                    pend_w        = 1'b1;
                    pend_addr     = bus.load_addr;
                    pend_data     = bus.load_data;
                    last_was_load = 1'b1;
                end
            end
            step();
            if (gcount == 4) begin
                bus.fetch_req = 1'b0;
                bus.load_req  = 1'b0;
            end
            if (last_was_load) begin
                bus.load_addr = bus.load_addr + 10'd1;
                bus.load_data = bus.load_data + 8'h11;
            end
        end
        check("tie_count", 32'(gcount), 32'd4);
        check("tie_order", 32'(order), 32'b1010);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
